// File: rtl/cdr_loop_gear_ctrl.sv
// cdr_loop_gear_ctrl: loop-gain sequencer and lock detector for the baud-rate
// PAM4 CDR. Measures the peak-to-peak phase excursion over fixed strobe windows
// and steps the loop through ACQ -> TRK -> LOCKED gain settings, reporting lock
// and a sticky loss-of-lock flag.
module cdr_loop_gear_ctrl #(
  parameter int unsigned PHI_W       = 16,
  parameter int unsigned WIN_LOG2    = 6,
  parameter int unsigned LOCK_THR    = 256,
  parameter int unsigned LOCK_WINS   = 4,
  parameter int unsigned UNLOCK_WINS = 2,
  parameter int unsigned ACQ_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sample_en,
  input  logic signed [PHI_W-1:0] phi,
  input  logic                    clear_lol,
  output logic [1:0]              kp_sel,
  output logic [1:0]              ki_sel,
  output logic                    freeze,
  output logic                    lock,
  output logic                    lol,
  output logic [1:0]              state
);

  localparam int unsigned WIN_W  = (WIN_LOG2 == 0) ? 1 : WIN_LOG2;
  localparam int unsigned SPAN_W = PHI_W + 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TCNT_W = 8;

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'((1 << WIN_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [SPAN_W-1:0] THR      = SPAN_W'(LOCK_THR);
  localparam logic [CNT_W-1:0]  LOCK_N   = CNT_W'(LOCK_WINS);
  localparam logic [CNT_W-1:0]  UNLOCK_N = CNT_W'(UNLOCK_WINS);
  localparam logic [TCNT_W-1:0] TMO_N    = TCNT_W'(ACQ_TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_TRK    = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic signed [PHI_W-1:0] min_q, min_d;
  logic signed [PHI_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]        qcnt_q, qcnt_d;
  logic [CNT_W-1:0]        ncnt_q, ncnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic                    lol_q, lol_d;
  logic [1:0]              kp_q, kp_d;
  logic [1:0]              ki_q, ki_d;
  logic                    freeze_q, freeze_d;
  logic                    lock_q, lock_d;

  logic                    win_first_c;
  logic                    win_last_c;
  logic signed [PHI_W-1:0] lo_c;
  logic signed [PHI_W-1:0] hi_c;
  logic [SPAN_W-1:0]       span_c;
  logic                    quiet_c;
  logic [CNT_W-1:0]        qn_c;
  logic [CNT_W-1:0]        nn_c;
  logic [TCNT_W-1:0]       tn_c;
  logic                    lol_set_c;

  // Running min/max including the current phase word, and the window verdict
  always_comb begin
    win_first_c = (win_q == '0);
    win_last_c  = (win_q == WIN_LAST);
    lo_c        = min_q;
    hi_c        = max_q;
    if (win_first_c || (phi < min_q)) begin
      lo_c = phi;
    end
    if (win_first_c || (phi > max_q)) begin
      hi_c = phi;
    end
    // sign-extend by one bit so full-scale excursions never wrap
    span_c  = {hi_c[PHI_W-1], hi_c} - {lo_c[PHI_W-1], lo_c};
    quiet_c = (span_c <= THR);
  end

  // Counter updates a completed window would produce
  always_comb begin
    qn_c = '0;
    nn_c = '0;
    tn_c = tcnt_q;
    if (quiet_c) begin
      qn_c = (qcnt_q == CNT_MAX) ? qcnt_q : qcnt_q + CNT_W'(1);
    end else begin
      nn_c = (ncnt_q == CNT_MAX) ? ncnt_q : ncnt_q + CNT_W'(1);
    end
    if (state_q == ST_ACQ) begin
      tn_c = tcnt_q + TCNT_W'(1);
    end
  end

  // Next-state, window bookkeeping and sticky loss-of-lock
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    min_d     = min_q;
    max_d     = max_q;
    qcnt_d    = qcnt_q;
    ncnt_d    = ncnt_q;
    tcnt_d    = tcnt_q;
    lol_set_c = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQ;
    end else if (sample_en) begin
      min_d = lo_c;
      max_d = hi_c;
      if (!win_last_c) begin
        win_d = win_q + WIN_W'(1);
      end else begin
        win_d  = '0;
        qcnt_d = qn_c;
        ncnt_d = nn_c;
        tcnt_d = tn_c;
        case (state_q)
          ST_ACQ: begin
            if (qn_c >= LOCK_N) begin
              state_d = ST_TRK;
            end else if (tn_c >= TMO_N) begin
              lol_set_c = 1'b1;
              qcnt_d    = '0;
              ncnt_d    = '0;
              tcnt_d    = '0;
            end
          end
          ST_TRK: begin
            if (qn_c >= LOCK_N) begin
              state_d = ST_LOCKED;
            end else if (nn_c >= UNLOCK_N) begin
              state_d = ST_ACQ;
            end
          end
          ST_LOCKED: begin
            if (nn_c >= UNLOCK_N) begin
              state_d   = ST_ACQ;
              lol_set_c = 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    // every state change, and any disable, restarts measurement from scratch
    if (!en || (state_d != state_q)) begin
      win_d  = '0;
      qcnt_d = '0;
      ncnt_d = '0;
      tcnt_d = '0;
    end

    if (lol_set_c) begin
      lol_d = 1'b1;
    end else if (clear_lol) begin
      lol_d = 1'b0;
    end else begin
      lol_d = lol_q;
    end
  end

  // Gain/freeze/lock decode for the state being entered
  always_comb begin
    kp_d     = 2'd0;
    ki_d     = 2'd0;
    freeze_d = 1'b0;
    lock_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        freeze_d = 1'b1;
      end
      ST_ACQ: begin
        kp_d = 2'd3;
        ki_d = 2'd3;
      end
      ST_TRK: begin
        kp_d = 2'd2;
        ki_d = 2'd1;
      end
      ST_LOCKED: begin
        kp_d   = 2'd1;
        lock_d = 1'b1;
      end
      default: begin
        freeze_d = 1'b1;
      end
    endcase
  end

  // State, window and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      qcnt_q   <= '0;
      ncnt_q   <= '0;
      tcnt_q   <= '0;
      lol_q    <= 1'b0;
      kp_q     <= 2'd0;
      ki_q     <= 2'd0;
      freeze_q <= 1'b1;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      min_q    <= min_d;
      max_q    <= max_d;
      qcnt_q   <= qcnt_d;
      ncnt_q   <= ncnt_d;
      tcnt_q   <= tcnt_d;
      lol_q    <= lol_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      freeze_q <= freeze_d;
      lock_q   <= lock_d;
    end
  end

  assign state  = state_q;
  assign kp_sel = kp_q;
  assign ki_sel = ki_q;
  assign freeze = freeze_q;
  assign lock   = lock_q;
  assign lol    = lol_q;

endmodule

// File: tb/tb_cdr_loop_gear_ctrl.sv
// Scoreboard bench for cdr_loop_gear_ctrl: a driver applies stimulus at the
// falling edge and pushes the reference model's expected outputs; a monitor
// pops and compares after each rising edge.
module tb_cdr_loop_gear_ctrl;

  localparam int PHI_W = 16;
  localparam int WIN   = 4;
  localparam int THR   = 8;
  localparam int LW    = 2;
  localparam int UW    = 2;
  localparam int TMO   = 3;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    sample_en;
  logic signed [PHI_W-1:0] phi;
  logic                    clear_lol;
  logic [1:0]              kp_sel;
  logic [1:0]              ki_sel;
  logic                    freeze;
  logic                    lock;
  logic                    lol;
  logic [1:0]              state;

  cdr_loop_gear_ctrl #(
    .PHI_W(16), .WIN_LOG2(2), .LOCK_THR(8),
    .LOCK_WINS(2), .UNLOCK_WINS(2), .ACQ_TIMEOUT(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sample_en(sample_en), .phi(phi),
    .clear_lol(clear_lol), .kp_sel(kp_sel), .ki_sel(ki_sel), .freeze(freeze),
    .lock(lock), .lol(lol), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int m_state;  // 0 idle, 1 acq, 2 trk, 3 locked
  int m_q, m_n, m_t;
  bit m_lol;
  int m_win[$];

  logic [8:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  function automatic void m_restart();
    m_win.delete();
    m_q = 0;
    m_n = 0;
    m_t = 0;
  endfunction

  function automatic void m_goto(input int s);
    m_state = s;
    m_restart();
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit s,
                                     input int p, input bit c);
    bit set_l;
    int lo, hi;
    set_l = 1'b0;
    if (r) begin
      m_state = 0;
      m_restart();
      m_lol = 1'b0;
      return;
    end
    if (!e) begin
      m_goto(0);
    end else if (m_state == 0) begin
      m_goto(1);
    end else if (s) begin
      m_win.push_back(p);
      if (m_win.size() == WIN) begin
        lo = m_win[0];
        hi = m_win[0];
        foreach (m_win[i]) begin
          if (m_win[i] < lo) lo = m_win[i];
          if (m_win[i] > hi) hi = m_win[i];
        end
        m_win.delete();
        if (hi - lo <= THR) begin
          m_q = (m_q < 15) ? m_q + 1 : 15;
          m_n = 0;
        end else begin
          m_n = (m_n < 15) ? m_n + 1 : 15;
          m_q = 0;
        end
        if (m_state == 1) m_t = m_t + 1;
        if (m_state == 1) begin
          if (m_q >= LW) m_goto(2);
          else if (m_t >= TMO) begin
            set_l = 1'b1;
            m_q = 0; m_n = 0; m_t = 0;
          end
        end else if (m_state == 2) begin
          if (m_q >= LW) m_goto(3);
          else if (m_n >= UW) m_goto(1);
        end else if (m_state == 3) begin
          if (m_n >= UW) begin
            m_goto(1);
            set_l = 1'b1;
          end
        end
      end
    end
    if (set_l) m_lol = 1'b1;
    else if (c) m_lol = 1'b0;
  endfunction

  function automatic logic [8:0] model_out();
    logic [1:0] kp, ki;
    case (m_state)
      1: begin kp = 2'd3; ki = 2'd3; end
      2: begin kp = 2'd2; ki = 2'd1; end
      3: begin kp = 2'd1; ki = 2'd0; end
      default: begin kp = 2'd0; ki = 2'd0; end
    endcase
    return {2'(m_state), kp, ki, 1'(m_state == 0), 1'(m_state == 3), m_lol};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e, input bit s, input int p, input bit c);
    @(negedge clk);
    rst       = r;
    en        = e;
    sample_en = s;
    phi       = PHI_W'(p);
    clear_lol = c;
    model_step(r, e, s, p, c);
    exp_q.push_back(model_out());
  endtask

  task automatic idle_en(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  // strobe with a few enabled idle cycles before it
  task automatic strobe(input int p, input int gap);
    idle_en(gap);
    drive(1'b0, 1'b1, 1'b1, p, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [8:0] act, expv;
    #1;
    cyc = cyc + 1;
    if (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      act  = {state, kp_sel, ki_sel, freeze, lock, lol};
      checks = checks + 1;
      if (act !== expv) begin
        fails = fails + 1;
        $display("FAIL outputs cycle %0d {state,kp,ki,freeze,lock,lol}: got %b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                 cyc, act[8:7], act[6:5], act[4:3], act[2], act[1], act[0],
                 expv[8:7], expv[6:5], expv[4:3], expv[2], expv[1], expv[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit noisy;
    int base;
    rst = 1'b1; en = 1'b0; sample_en = 1'b0; phi = '0; clear_lol = 1'b0;
    m_state = 0; m_lol = 1'b0; m_restart();

    // reset with random inputs, then release with en low
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 5, 1'b0);

    // clean lock: strobe every 3 cycles, constant phase
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 18; i++) strobe(100, 2);

    // loss of lock, then clear
    for (int i = 0; i < 8; i++) strobe((i % 2 == 0) ? 50 : -50, 1);
    idle_en(2);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b1);

    // threshold boundary windows
    strobe(0, 0); strobe(8, 0); strobe(0, 0); strobe(8, 0);
    strobe(0, 1); strobe(9, 1); strobe(0, 1); strobe(9, 1);
    strobe(-32768, 0); strobe(32767, 0); strobe(-32768, 0); strobe(32767, 0);

    // acquisition timeout from a fresh ACQ entry
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++) strobe((i % 2 == 0) ? 1000 : -1000, int'($urandom_range(0, 2)));
    for (int i = 0; i < 11; i++) strobe((i % 2 == 0) ? 1000 : -1000, 1);
    idle_en(1);
    drive(1'b0, 1'b1, 1'b1, -1000, 1'b1);
    idle_en(2);

    // mid-operation abort in TRK, then fresh re-acquisition
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) strobe(-200, 1);
    for (int i = 0; i < 6; i++) strobe(-200, 1);
    drive(1'b0, 1'b0, 1'b1, -200, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) strobe(-200, 0);

    // randomized traffic: phases alternate between quiet and noisy regimes
    noisy = 1'b0;
    base  = 0;
    for (int i = 0; i < 4000; i++) begin
      int p;
      if ($urandom_range(0, 39) == 0) begin
        noisy = ~noisy;
        base  = int'($urandom_range(0, 2000)) - 1000;
      end
      p = noisy ? int'($urandom_range(0, 65535)) - 32768
                : base + int'($urandom_range(0, 8)) - 4;
      drive(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 79) != 0),
            1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 49) == 0));
    end
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);

    @(posedge clk);
    #3;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
